lol_writer: RTL and testbench
=============================

Name: lol_writer

Overview:
- Transmit side of the 3-bit "LOL" symbol stream; generates the symbol sequence that the stream reader decodes back into L/O/Y letter strobes.
- Accepts one letter request per handshake and emits that letter's symbols, one per clock, followed by a blank terminator.
- Drives 000 (blank) whenever idle. Its output connects directly to the reader's bits input.

Parameters:
- None. Symbol encodings are fixed by the protocol.

Ports:
- clk  input  1  clock; all state updates on the rising edge
- restart  input  1  synchronous active-high reset
- go  input  1  request strobe; sampled on the rising edge
- letter  input  2  00=L, 01=O, 10=Y, 11=invalid
- ready  output  1  go is accepted this cycle when high
- bits  output  3  registered symbol stream
- busy  output  1  high while a letter's symbols or terminator are on bits
- done  output  1  one-cycle pulse during the terminator cycle
- err  output  1  one-cycle pulse, cycle after a rejected request (go & ready & letter==11)

Behaviour:
- Interface (already decided): one clock, clk; reset is restart, synchronous and active-high.
- Symbol tables (each sequence includes the 000 terminator):
  - L: 111, 001, 000
  - O: 111, 101, 111, 000
  - Y: 100, 011, 100, 000
- States: IDLE, SYM1, SYM2, SYM3, TERM. A 2-bit letter register is loaded on acceptance. L goes SYM2 -> TERM and skips SYM3.
- All outputs except ready are registered; ready is combinational from state.
- Reset, or restart at any point: state=IDLE and bits=000, busy=0, done=0, err=0, letter register=00. This takes effect the cycle after restart is sampled. restart overrides go.
- ready = (state==IDLE) | (state==TERM).
- Acceptance: go & ready & letter!=11 at edge t.
  - The first symbol appears on bits for cycle t+1; busy=1 from t+1.
  - L occupies 3 cycles (t+1..t+3), O and Y 4 cycles (t+1..t+4). The last cycle of each is TERM: bits=000, done=1, busy=1.
- Back-to-back: a go accepted during TERM goes to SYM1 with the new letter. The first symbol follows the 000 with no extra blank, which is legal for the reader (end state -> next letter).
- No accepted go during TERM: the next state is IDLE and bits stays 000.
- go while not ready: ignored, no state change, no err.
- Invalid letter (11) with go & ready: not accepted; state follows the no-go path; err=1 the next cycle.
- letter is sampled only at acceptance; changes during busy have no effect.
- bits never carries a value outside the table for the active letter or 000.

Optional Feature:
- Macro: LOL_WRITER_QUEUE_EN.
- Defined: adds a one-entry pending request register (valid + 2-bit letter).
  - ready = ~pending_valid.
  - go with a valid letter while busy and not in TERM is captured into pending.
  - In TERM, a valid pending request launches into SYM1 next cycle and clears pending.
  - In TERM with pending empty, a direct go launches as in base behaviour.
  - An invalid letter is never queued; it produces err.
  - restart clears pending.
- Undefined: no pending register; ready and behaviour exactly as in the base spec.

Test Plan:
- restart=1 for 2 cycles, then idle 3 cycles -> bits=000, busy=0, done=0, err=0, ready=1 throughout.
- go=1, letter=00 at edge t -> bits 111, 001, 000 at t+1..t+3; done=1 only at t+3; busy=1 t+1..t+3; bits=000, busy=0 at t+4.
- letter=01 accepted, then letter=10 asserted with go during the O terminator cycle -> bits 111, 101, 111, 000, 100, 011, 100, 000 with no gap; two done pulses, 4 cycles apart.
- go=1, letter=11 while IDLE -> err=1 next cycle only; bits=000, busy=0. Also go during SYM2 of a Y -> ignored; Y sequence unchanged.
- restart asserted during SYM2 of O -> next cycle bits=000, busy=0, done=0; a following go with letter=00 produces a clean L sequence.
- Macro defined: go letter=00 at t, go letter=10 at t+1 (ready=1, then ready=0 until launch) -> 111, 001, 000, 100, 011, 100, 000 back-to-back; with the macro undefined, the second request is ignored.

Source files
------------

// File: rtl/lol_writer.sv
// Transmit side of the 3-bit LOL symbol stream: one letter per handshake, then a blank terminator.
// Optional one-entry request queue enabled by defining LOL_WRITER_QUEUE_EN.
module lol_writer (
  input  logic       clk,
  input  logic       restart,
  input  logic       go,
  input  logic [1:0] letter,
  output logic       ready,
  output logic [2:0] bits,
  output logic       busy,
  output logic       done,
  output logic       err
);

  // state | meaning
  // IDLE  | no letter in flight, bits=000
  // SYM1  | first symbol of the active letter on bits
  // SYM2  | second symbol
  // SYM3  | third symbol (O and Y only)
  // TERM  | 000 terminator, done pulse, may accept the next letter
  typedef enum logic [2:0] {IDLE, SYM1, SYM2, SYM3, TERM} state_t;

  localparam logic [1:0] LET_L = 2'b00;
  localparam logic [1:0] LET_O = 2'b01;
  localparam logic [1:0] LET_Y = 2'b10;
  localparam logic [1:0] LET_X = 2'b11;

  state_t     state, state_nx;
  logic [1:0] letter_q, letter_nx;
  logic [2:0] bits_nx;
  logic       req_valid, err_nx;

`ifdef LOL_WRITER_QUEUE_EN
  logic       pend_v, pend_v_nx;
  logic [1:0] pend_l, pend_l_nx;

  assign ready = ~pend_v;
`else
  assign ready = (state == IDLE) | (state == TERM);
`endif

  always_comb begin
    req_valid = go & ready & (letter != LET_X);
    err_nx    = go & ready & (letter == LET_X);
    state_nx  = state;
    letter_nx = letter_q;
`ifdef LOL_WRITER_QUEUE_EN
    pend_v_nx = pend_v;
    pend_l_nx = pend_l;
`endif
    case (state)
      IDLE: if (req_valid) begin
        state_nx  = SYM1;
        letter_nx = letter;
      end
      SYM1: state_nx = SYM2;
      SYM2: state_nx = (letter_q == LET_L) ? TERM : SYM3;
      SYM3: state_nx = TERM;
      TERM: begin
        state_nx = IDLE;
`ifdef LOL_WRITER_QUEUE_EN
        if (pend_v) begin
          state_nx  = SYM1;
          letter_nx = pend_l;
          pend_v_nx = 1'b0;
        end else
`endif
        if (req_valid) begin
          state_nx  = SYM1;
          letter_nx = letter;
        end
      end
      default: state_nx = IDLE;
    endcase
`ifdef LOL_WRITER_QUEUE_EN
    // Mid-letter requests wait in the pending slot until the terminator.
    if (req_valid && (state == SYM1 || state == SYM2 || state == SYM3)) begin
      pend_v_nx = 1'b1;
      pend_l_nx = letter;
    end
`endif
  end

  always_comb begin
    bits_nx = 3'b000;
    case (state_nx)
      SYM1: case (letter_nx)
        LET_L, LET_O: bits_nx = 3'b111;
        LET_Y:        bits_nx = 3'b100;
        default:      bits_nx = 3'b000;
      endcase
      SYM2: case (letter_nx)
        LET_L:   bits_nx = 3'b001;
        LET_O:   bits_nx = 3'b101;
        LET_Y:   bits_nx = 3'b011;
        default: bits_nx = 3'b000;
      endcase
      SYM3: case (letter_nx)
        LET_O:   bits_nx = 3'b111;
        LET_Y:   bits_nx = 3'b100;
        default: bits_nx = 3'b000;
      endcase
      default: bits_nx = 3'b000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (restart) begin
      state    <= IDLE;
      letter_q <= LET_L;
      bits     <= 3'b000;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
`ifdef LOL_WRITER_QUEUE_EN
      pend_v   <= 1'b0;
      pend_l   <= LET_L;
`endif
    end else begin
      state    <= state_nx;
      letter_q <= letter_nx;
      bits     <= bits_nx;
      busy     <= (state_nx != IDLE);
      done     <= (state_nx == TERM);
      err      <= err_nx;
`ifdef LOL_WRITER_QUEUE_EN
      pend_v   <= pend_v_nx;
      pend_l   <= pend_l_nx;
`endif
    end
  end

endmodule

// File: tb/tb_lol_writer.sv
// Bench for lol_writer: directed protocol scenarios followed by random traffic,
// all checked against a symbol-queue model of the letter tables.
module tb_lol_writer;

  logic       clk = 1'b0;
  logic       restart, go;
  logic [1:0] letter;
  logic       ready, busy, done, err;
  logic [2:0] bits;

  lol_writer dut (
    .clk    (clk),
    .restart(restart),
    .go     (go),
    .letter (letter),
    .ready  (ready),
    .bits   (bits),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;
  bit started = 1'b0;

  // Model: symbols still to be emitted after the one currently on bits.
  logic [2:0] symq[$];
  logic [2:0] m_bits = 3'b000;
  logic       m_busy = 1'b0, m_done = 1'b0, m_err = 1'b0;
  logic       pend_v = 1'b0;
  logic [1:0] pend_l = 2'b00;

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_mis++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic push_letter(input logic [1:0] l);
    case (l)
      2'b00: begin symq.push_back(3'b111); symq.push_back(3'b001); symq.push_back(3'b000); end
      2'b01: begin symq.push_back(3'b111); symq.push_back(3'b101); symq.push_back(3'b111); symq.push_back(3'b000); end
      2'b10: begin symq.push_back(3'b100); symq.push_back(3'b011); symq.push_back(3'b100); symq.push_back(3'b000); end
      default: ;
    endcase
  endtask

  task automatic step(input logic g, input logic [1:0] l, input logic r);
    logic rdy_m, acc;
    go = g; letter = l; restart = r;
    #1;
`ifdef LOL_WRITER_QUEUE_EN
    rdy_m = !pend_v;
`else
    rdy_m = (symq.size() == 0);
`endif
    if (started) chk("ready", {2'b00, ready}, {2'b00, rdy_m});
    if (r) begin
      symq.delete();
      pend_v = 1'b0;
      m_bits = 3'b000; m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_err = g && rdy_m && (l == 2'b11);
      acc   = g && rdy_m && (l != 2'b11);
`ifdef LOL_WRITER_QUEUE_EN
      if (symq.size() == 0) begin
        if (pend_v) begin push_letter(pend_l); pend_v = 1'b0; end
        else if (acc) push_letter(l);
      end else if (acc) begin
        pend_v = 1'b1; pend_l = l;
      end
`else
      if (acc) push_letter(l);
`endif
      if (symq.size() > 0) begin
        m_bits = symq.pop_front();
        m_busy = 1'b1;
        m_done = (symq.size() == 0);
      end else begin
        m_bits = 3'b000; m_busy = 1'b0; m_done = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    chk("bits", bits, m_bits);
    chk("busy", {2'b00, busy}, {2'b00, m_busy});
    chk("done", {2'b00, done}, {2'b00, m_done});
    chk("err",  {2'b00, err},  {2'b00, m_err});
    started = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0);
  endtask

  initial begin
    // reset, then quiet
    step(1'b0, 2'b00, 1'b1);
    step(1'b1, 2'b01, 1'b1);
    idle(3);
    // single L, with absolute checks alongside the model
    step(1'b1, 2'b00, 1'b0);
    chk("l_sym1", bits, 3'b111);
    step(1'b0, 2'b00, 1'b0);
    chk("l_sym2", bits, 3'b001);
    step(1'b0, 2'b00, 1'b0);
    chk("l_term_done", {2'b00, done}, 3'b001);
    idle(2);
    // O then Y launched from the O terminator
    step(1'b1, 2'b01, 1'b0);
    idle(3);
    step(1'b1, 2'b10, 1'b0);
    chk("oy_no_gap", bits, 3'b100);
    idle(4);
    // invalid letter, then go during SYM2 of Y
    step(1'b1, 2'b11, 1'b0);
    idle(1);
    step(1'b1, 2'b10, 1'b0);
    idle(1);
    step(1'b1, 2'b00, 1'b0);
    idle(4);
    // restart during SYM2 of O overrides go, then a clean L
    step(1'b1, 2'b01, 1'b0);
    idle(1);
    step(1'b1, 2'b10, 1'b1);
    step(1'b1, 2'b00, 1'b0);
    idle(4);
    // back-to-back requests: queued when enabled, ignored otherwise
    step(1'b1, 2'b00, 1'b0);
    step(1'b1, 2'b10, 1'b0);
    idle(7);
    // random traffic
    for (int i = 0; i < 800; i++) begin
      step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           1'($urandom_range(0, 39) == 0));
    end
    idle(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
